vend_ctrl: RTL and testbench
============================

# vend_ctrl

Transaction controller for the coin-operated vending path. Accumulates coin credit, arbitrates four product slots onto a single shared dispenser, tracks per-slot stock, and drives a one-rupee change/refund ejector. Sits between the coin acceptor and selection keypad on one side and the dispenser and change hopper on the other.

## Interface
- PRICE, 3, product price in rupees (1..MAX_CREDIT)
- MAX_CREDIT, 7, credit ceiling in rupees (≤7)
- TIMEOUT, 4, idle cycles in CREDIT before automatic refund (1..15)
- STOCK_INIT, 3, per-slot stock after reset or restock (0..7)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- coin  in  2  coin this cycle: 0 none, 1 = Rs1, 2 = Rs2, 3 invalid
- sel_valid  in  1  selection strobe, one cycle
- sel  in  2  selected slot 0..3, valid with sel_valid
- restock  in  1  reload all slots to STOCK_INIT
- vend_req  out  1  dispense request, level, held until vend_ack
- vend_slot  out  2  slot to dispense, stable while vend_req
- vend_ack  in  1  dispenser done
- chg_req  out  1  eject one Rs1 coin, level, held until chg_ack
- chg_ack  in  1  one coin ejected
- credit  out  3  current credit in rupees
- coin_reject  out  1  one-cycle pulse: coin refused
- sel_reject  out  1  one-cycle pulse: selection refused
- sold_out  out  4  bit i set when stock[i] == 0

## Operation
- States: IDLE, CREDIT, VEND, CHANGE. Reset → IDLE.
- IDLE: credit 0. coin 1/2 → credit = coin, CREDIT, timer cleared. coin 3 → coin_reject. sel_valid → sel_reject. restock → all stock = STOCK_INIT (accepted only in IDLE, ignored elsewhere).
- CREDIT:
  - coin 1/2 with credit + coin ≤ MAX_CREDIT → credit += coin, timer cleared.
  - coin 1/2 overflowing MAX_CREDIT, or coin 3 → coin_reject, credit unchanged.
  - sel_valid, credit ≥ PRICE, stock[sel] > 0 → latch vend_slot = sel, VEND.
  - sel_valid otherwise → sel_reject, stay.
  - coin ≠ 0 and sel_valid same cycle: coin processed, selection dropped silently (no sel_reject).
  - no coin and no accepted selection: timer += 1; timer reaching TIMEOUT → CHANGE (full refund).
- VEND: vend_req = 1. On vend_ack: stock[vend_slot] -= 1, credit -= PRICE; → CHANGE if new credit > 0, else IDLE.
- CHANGE: chg_req = 1 while credit > 0. Each chg_ack: credit -= 1; credit reaching 0 → IDLE.
- VEND and CHANGE: any coin ≠ 0 → coin_reject; sel_valid → sel_reject.
- Width rules: credit 3-bit unsigned, never exceeds MAX_CREDIT, never underflows. Stock 3-bit per slot, decremented only on vend_ack, never below 0. Timer 4-bit.

## Timing
- All outputs registered. Reset values: vend_req 0, vend_slot 0, chg_req 0, credit 0, coin_reject 0, sel_reject 0, stock = STOCK_INIT (sold_out = 0 if STOCK_INIT > 0, else 4'hF).
- Inputs sampled at posedge; credit, state and reject pulses visible in the following cycle.
- vend_req rises the cycle after accepted sel_valid; falls the cycle after vend_ack. chg_req same rule with chg_ack; chg_req re-asserts next cycle if credit remains (one ack per cycle max consumed).
- vend_ack/chg_ack while the matching req is low: ignored.
- Timeout: with no activity after entering CREDIT, CHANGE entered exactly TIMEOUT cycles later.
- sold_out reflects stock the cycle after vend_ack or restock.
- rst mid-transaction: next cycle IDLE, credit 0, requests dropped, stock reloaded to STOCK_INIT; no refund issued.

## Test plan
- Reset, coin 1 then coin 2, sel_valid sel=2 → credit 1, 3; vend_req=1 vend_slot=2; vend_ack → stock[2]=2, credit 0, IDLE, chg_req never asserted.
- Coins 2,2 (credit 4), sel 0, vend_ack → chg_req asserted, one chg_ack → credit 0, IDLE.
- Coins 2,2,2 → credit 6; further coin 2 → coin_reject pulse, credit stays 6; coin 1 → credit 7.
- Coin 1, no activity → CHANGE after 4 cycles, chg_req, chg_ack → credit 0, IDLE; sel_valid with credit 1 earlier → sel_reject.
- Three vends from slot 1 → sold_out[1]=1; fourth sel 1 → sel_reject; restock in IDLE → sold_out=0, stock all 3.
- rst asserted during VEND with vend_req high → next cycle vend_req 0, credit 0, IDLE; coin during VEND → coin_reject.

Source files
------------

// File: rtl/vend_ctrl_if.sv
// Keypad/coin-acceptor and dispenser/hopper signals for the vending controller.
// The bench drives through the master modport; vend_ctrl connects to the slave modport.
interface vend_ctrl_if;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       restock;
    logic       vend_req;
    logic [1:0] vend_slot;
    logic       vend_ack;
    logic       chg_req;
    logic       chg_ack;
    logic [2:0] credit;
    logic       coin_reject;
    logic       sel_reject;
    logic [3:0] sold_out;

    modport master (
        output coin, sel_valid, sel, restock, vend_ack, chg_ack,
        input  vend_req, vend_slot, chg_req, credit, coin_reject, sel_reject, sold_out
    );

    modport slave (
        input  coin, sel_valid, sel, restock, vend_ack, chg_ack,
        output vend_req, vend_slot, chg_req, credit, coin_reject, sel_reject, sold_out
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit, slot arbitration onto one dispenser,
// per-slot stock tracking and a one-rupee change ejector.
//
// state    | meaning
// S_IDLE   | no credit, waiting for first coin; restock accepted here only
// S_CREDIT | accumulating coins, idle timer running toward automatic refund
// S_VEND   | vend_req held until the dispenser acknowledges
// S_CHANGE | ejecting one rupee per chg_ack until credit is zero
module vend_ctrl #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int TIMEOUT    = 4,
    parameter int STOCK_INIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    vend_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      credit_q, credit_d;
    logic [3:0]      timer_q, timer_d;
    logic [3:0][2:0] stock_q, stock_d;
    logic            vend_req_q, vend_req_d;
    logic [1:0]      vend_slot_q, vend_slot_d;
    logic            chg_req_q, chg_req_d;
    logic            coin_rej_q, coin_rej_d;
    logic            sel_rej_q, sel_rej_d;
    logic [3:0]      sold_out_q, sold_out_d;

    logic [3:0]      coin_sum;
    logic [3:0]      timer_inc;
    logic [3:0][2:0] stock_full;
    logic [3:0]      sold_out_init;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stock_full[i]    = 3'(STOCK_INIT);
            sold_out_init[i] = (STOCK_INIT == 0);
        end
    end

    assign coin_sum  = {1'b0, credit_q} + {2'b00, bus.coin};
    assign timer_inc = timer_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        timer_d     = timer_q;
        stock_d     = stock_q;
        vend_req_d  = vend_req_q;
        vend_slot_d = vend_slot_q;
        chg_req_d   = chg_req_q;
        coin_rej_d  = 1'b0;
        sel_rej_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                credit_d = 3'd0;
                if (bus.coin == 2'd3) begin
                    coin_rej_d = 1'b1;
                end else if (bus.coin != 2'd0) begin
                    credit_d = {1'b0, bus.coin};
                    timer_d  = 4'd0;
                    state_d  = S_CREDIT;
                end
                if (bus.sel_valid) sel_rej_d = 1'b1;
                if (bus.restock)   stock_d   = stock_full;
            end

            S_CREDIT: begin
                // A coin takes priority; a simultaneous selection is dropped without a reject pulse.
                if (bus.coin != 2'd0) begin
                    if (bus.coin == 2'd3 || coin_sum > 4'(MAX_CREDIT)) begin
                        coin_rej_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[2:0];
                        timer_d  = 4'd0;
                    end
                end else if (bus.sel_valid && credit_q >= 3'(PRICE)
                             && stock_q[bus.sel] != 3'd0) begin
                    vend_slot_d = bus.sel;
                    vend_req_d  = 1'b1;
                    state_d     = S_VEND;
                end else begin
                    if (bus.sel_valid) sel_rej_d = 1'b1;
                    if (timer_inc == 4'(TIMEOUT)) begin
                        timer_d   = 4'd0;
                        chg_req_d = 1'b1;
                        state_d   = S_CHANGE;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end

            S_VEND: begin
                if (bus.coin != 2'd0) coin_rej_d = 1'b1;
                if (bus.sel_valid)    sel_rej_d  = 1'b1;
                if (bus.vend_ack && vend_req_q) begin
                    vend_req_d = 1'b0;
                    if (stock_q[vend_slot_q] != 3'd0)
                        stock_d[vend_slot_q] = stock_q[vend_slot_q] - 3'd1;
                    credit_d = credit_q - 3'(PRICE);
                    if (credit_q != 3'(PRICE)) begin
                        chg_req_d = 1'b1;
                        state_d   = S_CHANGE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                if (bus.coin != 2'd0) coin_rej_d = 1'b1;
                if (bus.sel_valid)    sel_rej_d  = 1'b1;
                // Request drops for one cycle after each ack so each coin gets its own handshake.
                if (bus.chg_ack && chg_req_q) begin
                    chg_req_d = 1'b0;
                    credit_d  = credit_q - 3'd1;
                    if (credit_q == 3'd1) state_d = S_IDLE;
                end else if (credit_q != 3'd0) begin
                    chg_req_d = 1'b1;
                end else begin
                    chg_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < 4; i++) sold_out_d[i] = (stock_d[i] == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            credit_q    <= 3'd0;
            timer_q     <= 4'd0;
            stock_q     <= stock_full;
            vend_req_q  <= 1'b0;
            vend_slot_q <= 2'd0;
            chg_req_q   <= 1'b0;
            coin_rej_q  <= 1'b0;
            sel_rej_q   <= 1'b0;
            sold_out_q  <= sold_out_init;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            timer_q     <= timer_d;
            stock_q     <= stock_d;
            vend_req_q  <= vend_req_d;
            vend_slot_q <= vend_slot_d;
            chg_req_q   <= chg_req_d;
            coin_rej_q  <= coin_rej_d;
            sel_rej_q   <= sel_rej_d;
            sold_out_q  <= sold_out_d;
        end
    end

    assign bus.vend_req    = vend_req_q;
    assign bus.vend_slot   = vend_slot_q;
    assign bus.chg_req     = chg_req_q;
    assign bus.credit      = credit_q;
    assign bus.coin_reject = coin_rej_q;
    assign bus.sel_reject  = sel_rej_q;
    assign bus.sold_out    = sold_out_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: vector table through a scoreboard queue,
// plus hand-written timeout and reset-during-vend sequences.
module tb_vend_ctrl;

    localparam int PRICE      = 3;
    localparam int MAX_CREDIT = 7;
    localparam int TIMEOUT    = 4;
    localparam int STOCK_INIT = 3;

    typedef struct {
        logic       rst;
        logic [1:0] coin;
        logic       sel_valid;
        logic [1:0] sel;
        logic       restock;
        logic       vend_ack;
        logic       chg_ack;
        logic [2:0] e_credit;
        logic       e_vend_req;
        logic [1:0] e_vend_slot;
        logic       e_chg_req;
        logic       e_coin_rej;
        logic       e_sel_rej;
        logic [3:0] e_sold_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_idx = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    vend_ctrl_if bus();

    vend_ctrl #(
        .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .TIMEOUT(TIMEOUT), .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic void add(
        input logic r, input logic [1:0] c, input logic sv, input logic [1:0] s,
        input logic rs, input logic va, input logic ca,
        input logic [2:0] cr, input logic vr, input logic [1:0] vs, input logic cq,
        input logic cj, input logic sj, input logic [3:0] so);
        vec_t v;
        v.rst = r; v.coin = c; v.sel_valid = sv; v.sel = s; v.restock = rs;
        v.vend_ack = va; v.chg_ack = ca;
        v.e_credit = cr; v.e_vend_req = vr; v.e_vend_slot = vs; v.e_chg_req = cq;
        v.e_coin_rej = cj; v.e_sel_rej = sj; v.e_sold_out = so;
        vecs.push_back(v);
    endfunction

    task automatic check_outputs(input vec_t e, input int idx);
        cmp("credit",      idx, int'(bus.credit),      int'(e.e_credit));
        cmp("vend_req",    idx, int'(bus.vend_req),    int'(e.e_vend_req));
        cmp("vend_slot",   idx, int'(bus.vend_slot),   int'(e.e_vend_slot));
        cmp("chg_req",     idx, int'(bus.chg_req),     int'(e.e_chg_req));
        cmp("coin_reject", idx, int'(bus.coin_reject), int'(e.e_coin_rej));
        cmp("sel_reject",  idx, int'(bus.sel_reject),  int'(e.e_sel_rej));
        cmp("sold_out",    idx, int'(bus.sold_out),    int'(e.e_sold_out));
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst           = v.rst;
        bus.coin      = v.coin;
        bus.sel_valid = v.sel_valid;
        bus.sel       = v.sel;
        bus.restock   = v.restock;
        bus.vend_ack  = v.vend_ack;
        bus.chg_ack   = v.chg_ack;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(e, vec_idx);
        vec_idx++;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        rst = 1'b0; bus.coin = 2'd0; bus.sel_valid = 1'b0; bus.sel = 2'd0;
        bus.restock = 1'b0; bus.vend_ack = 1'b0; bus.chg_ack = 1'b0;
    endtask

    initial begin
        int   cycles;
        vec_t v;

        bus.coin = 2'd0; bus.sel_valid = 1'b0; bus.sel = 2'd0;
        bus.restock = 1'b0; bus.vend_ack = 1'b0; bus.chg_ack = 1'b0;

        //  rst coin sv sel rs va ca | credit vreq slot creq crej srej sold
        add(0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 4'h0);
        add(0, 0, 1, 2, 0, 0, 0,   3, 1, 2, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,   3, 1, 2, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 2, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 2, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   4, 0, 2, 0, 0, 0, 4'h0);
        add(0, 0, 1, 0, 0, 0, 0,   4, 1, 0, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 4'h0);
        // credit ceiling and invalid coins
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1, 0, 4'h0);
        add(0, 1, 0, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0, 4'h0);
        add(0, 3, 0, 0, 0, 0, 0,   7, 0, 0, 0, 1, 0, 4'h0);
        add(0, 1, 0, 0, 0, 0, 0,   7, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 1, 1, 0, 0, 0,   7, 1, 1, 0, 0, 0, 4'h0);
        add(0, 1, 0, 0, 0, 0, 0,   7, 1, 1, 0, 1, 0, 4'h0);
        add(0, 0, 1, 0, 0, 0, 0,   7, 1, 1, 0, 0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   4, 0, 1, 1, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 1,   3, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 1,   2, 0, 1, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 1, 1, 1, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 4'h0);
        add(0, 3, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 0, 4'h0);
        // refund on timeout, rejected selection with too little credit
        add(0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 1, 1, 0, 0, 0,   1, 0, 1, 0, 0, 1, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 4'h0);
        // coin and selection together: selection silently dropped
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0, 4'h0);
        add(0, 1, 1, 3, 0, 0, 0,   3, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 1, 3, 0, 0, 0,   3, 1, 3, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 3, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 3, 0, 0, 0, 4'h0);
        // drain slot 1 to empty
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 3, 0, 0, 0, 4'h0);
        add(0, 1, 0, 0, 0, 0, 0,   3, 0, 3, 0, 0, 0, 4'h0);
        add(0, 0, 1, 1, 0, 0, 0,   3, 1, 1, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 4'h0);
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0, 4'h0);
        add(0, 1, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 1, 1, 0, 0, 0,   3, 1, 1, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 4'h2);
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0, 4'h2);
        add(0, 1, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0, 4'h2);
        add(0, 0, 1, 1, 0, 0, 0,   3, 0, 1, 0, 0, 1, 4'h2);
        add(0, 0, 0, 0, 1, 0, 0,   3, 0, 1, 0, 0, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 1,   2, 0, 1, 0, 0, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 1,   2, 0, 1, 1, 0, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 4'h2);
        add(0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 4'h0);
        // restocked slot 1 vends again
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0, 4'h0);
        add(0, 1, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0, 4'h0);
        add(0, 0, 1, 1, 0, 0, 0,   3, 1, 1, 0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0, 0, 4'h0);

        repeat (2) @(posedge clk);
        #1;
        v.e_credit = 3'd0; v.e_vend_req = 1'b0; v.e_vend_slot = 2'd0; v.e_chg_req = 1'b0;
        v.e_coin_rej = 1'b0; v.e_sel_rej = 1'b0; v.e_sold_out = 4'h0;
        check_outputs(v, -1);

        foreach (vecs[i]) apply(vecs[i]);

        // exact timeout latency, bounded wait
        v = vecs[0];
        v.e_vend_slot = 2'd1;
        apply(v);
        drive_idle();
        cycles = 0;
        while (!bus.chg_req && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        cmp("timeout_cycles", vec_idx, cycles, TIMEOUT);
        cmp("timeout_credit", vec_idx, int'(bus.credit), 1);
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, 4'h0);
        apply(vecs[$]);

        // reset while vending: requests drop, credit cleared, no refund
        add(0, 2, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0, 4'h0);
        apply(vecs[$]);
        add(0, 1, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0, 4'h0);
        apply(vecs[$]);
        add(0, 0, 1, 2, 0, 0, 0,   3, 1, 2, 0, 0, 0, 4'h0);
        apply(vecs[$]);
        add(0, 2, 0, 0, 0, 0, 0,   3, 1, 2, 0, 1, 0, 4'h0);
        apply(vecs[$]);
        add(1, 2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4'h0);
        apply(vecs[$]);
        add(0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 4'h0);
        apply(vecs[$]);
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 4'h0);
        apply(vecs[$]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
